// File: rtl/vga_scaled_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_scaled_reader                                                        |
// | VGA timing generator and framebuffer reader with 1x/2x/4x upscaling,     |
// | block-RAM latency compensation and a built-in test pattern.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module vga_scaled_reader #(
  parameter int   H_REZ        = 640,
  parameter int   H_FP         = 16,
  parameter int   H_SYNC       = 96,
  parameter int   H_BP         = 48,
  parameter int   V_REZ        = 480,
  parameter int   V_FP         = 10,
  parameter int   V_SYNC       = 2,
  parameter int   V_BP         = 33,
  parameter logic HSYNC_ACTIVE = 1'b0,
  parameter logic VSYNC_ACTIVE = 1'b0,
  parameter int   PIX_W        = 4,
  parameter int   ADDR_W       = 19,
  parameter int   MEM_LAT      = 2
) (
  input  logic              clk25,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] frame_addr,
  input  logic [PIX_W-1:0]  frame_pixel,
  output logic [3:0]        vga_red,
  output logic [3:0]        vga_green,
  output logic [3:0]        vga_blue,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic              de,
  output logic              frame_start
);

  localparam int c_H_TOTAL = H_REZ + H_FP + H_SYNC + H_BP;
  localparam int c_V_TOTAL = V_REZ + V_FP + V_SYNC + V_BP;
  // Counters are at least wide enough for the test-pattern bit taps
  localparam int c_HW_MIN  = $clog2(c_H_TOTAL);
  localparam int c_HW      = (c_HW_MIN < 10) ? 10 : c_HW_MIN;
  localparam int c_VW_MIN  = $clog2(c_V_TOTAL);
  localparam int c_VW      = (c_VW_MIN < 6) ? 6 : c_VW_MIN;

  localparam logic [c_HW-1:0]   c_H_LAST     = c_HW'(c_H_TOTAL - 1);
  localparam logic [c_HW-1:0]   c_H_ACT      = c_HW'(H_REZ);
  localparam logic [c_HW-1:0]   c_H_ACT_LAST = c_HW'(H_REZ - 1);
  localparam logic [c_HW-1:0]   c_HS_BEG     = c_HW'(H_REZ + H_FP);
  localparam logic [c_HW-1:0]   c_HS_END     = c_HW'(H_REZ + H_FP + H_SYNC);
  localparam logic [c_VW-1:0]   c_V_LAST     = c_VW'(c_V_TOTAL - 1);
  localparam logic [c_VW-1:0]   c_V_ACT      = c_VW'(V_REZ);
  localparam logic [c_VW-1:0]   c_VS_BEG     = c_VW'(V_REZ + V_FP);
  localparam logic [c_VW-1:0]   c_VS_END     = c_VW'(V_REZ + V_FP + V_SYNC);
  localparam logic [ADDR_W-1:0] c_H_REZ_A    = ADDR_W'(H_REZ);
  localparam logic [1:0]        c_MODE_TEST  = 2'd3;

  localparam int c_SB_W    = 9;
  localparam int c_SB_FS   = 8;
  localparam int c_SB_VS   = 7;
  localparam int c_SB_HS   = 6;
  localparam int c_SB_DE   = 5;
  localparam int c_SB_TEST = 4;
  localparam logic [c_SB_W-1:0] c_SB_RST = {1'b0, ~VSYNC_ACTIVE, ~HSYNC_ACTIVE, 6'b0};

  logic [c_HW-1:0]   r_hcnt;
  logic [c_VW-1:0]   r_vcnt;
  logic [1:0]        r_mode_q;
  logic [ADDR_W-1:0] r_frame_addr;
  logic [ADDR_W-1:0] r_line_base;
  logic [ADDR_W-1:0] r_col;
  logic [1:0]        r_sub;
  logic [c_SB_W-1:0] r_sb_pipe [MEM_LAT];
  logic [3:0]        r_rgb;
  logic              r_de;
  logic              r_hsync;
  logic              r_vsync;
  logic              r_fs;

  logic              w_origin;
  logic              w_h_act;
  logic              w_v_act;
  logic              w_active;
  logic [1:0]        w_mode;
  logic              w_test;
  logic [1:0]        w_sub_mask;
  logic [ADDR_W-1:0] w_src_w;
  logic [1:0]        w_vnext_lo;
  logic              w_repeat_done;
  logic              w_hsync;
  logic              w_vsync;
  logic [3:0]        w_level;
  logic [c_SB_W-1:0] w_sb;
  logic [c_SB_W-1:0] w_sb_last;
  logic [3:0]        w_pix4;
  logic [3:0]        w_gray;

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (r_hcnt == c_H_LAST) begin
      r_hcnt <= '0;
      r_vcnt <= (r_vcnt == c_V_LAST) ? '0 : r_vcnt + c_VW'(1);
    end else begin
      r_hcnt <= r_hcnt + c_HW'(1);
    end
  end

  assign w_origin = (r_hcnt == '0) && (r_vcnt == '0);
  assign w_h_act  = (r_hcnt < c_H_ACT);
  assign w_v_act  = (r_vcnt < c_V_ACT);
  assign w_active = w_h_act && w_v_act;
  // The origin pixel already belongs to the new frame, so it sees the live mode
  assign w_mode   = w_origin ? mode : r_mode_q;
  assign w_test   = (w_mode == c_MODE_TEST);

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_q <= 2'd0;
    end else if (w_origin) begin
      r_mode_q <= mode;
    end
  end

  always_comb begin
    w_sub_mask = 2'b00;
    case (w_mode)
      2'd1:    w_sub_mask = 2'b01;
      2'd2:    w_sub_mask = 2'b11;
      default: w_sub_mask = 2'b00;
    endcase
  end

  assign w_src_w       = c_H_REZ_A >> w_mode;
  assign w_vnext_lo    = r_vcnt[1:0] + 2'd1;
  assign w_repeat_done = ((w_vnext_lo & w_sub_mask) == 2'b00);

  // Incremental source addressing: col advances every 2^s pixels, the line
  // base advances by the source width only after the last repeat of a line.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_addr <= '0;
      r_line_base  <= '0;
      r_col        <= '0;
      r_sub        <= 2'd0;
    end else begin
      r_frame_addr <= (w_active && !w_test) ? (r_line_base + r_col) : '0;
      if (!w_v_act) begin
        r_line_base <= '0;
        r_col       <= '0;
        r_sub       <= 2'd0;
      end else if (w_h_act) begin
        if (r_hcnt == c_H_ACT_LAST) begin
          r_col <= '0;
          r_sub <= 2'd0;
          if (w_repeat_done) begin
            r_line_base <= r_line_base + w_src_w;
          end
        end else if (r_sub == w_sub_mask) begin
          r_sub <= 2'd0;
          r_col <= r_col + ADDR_W'(1);
        end else begin
          r_sub <= r_sub + 2'd1;
        end
      end
    end
  end

  assign w_hsync = ((r_hcnt >= c_HS_BEG) && (r_hcnt < c_HS_END)) ? HSYNC_ACTIVE : ~HSYNC_ACTIVE;
  assign w_vsync = ((r_vcnt >= c_VS_BEG) && (r_vcnt < c_VS_END)) ? VSYNC_ACTIVE : ~VSYNC_ACTIVE;
  assign w_level = r_hcnt[9:6] ^ {4{r_vcnt[5]}};
  assign w_sb    = {w_origin, w_vsync, w_hsync, w_active, w_test, w_level};

  // Sideband travels alongside the RAM read so sync and pixel stay aligned
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_LAT; i++) begin
        r_sb_pipe[i] <= c_SB_RST;
      end
    end else begin
      r_sb_pipe[0] <= w_sb;
      for (int i = 1; i < MEM_LAT; i++) begin
        r_sb_pipe[i] <= r_sb_pipe[i-1];
      end
    end
  end

  assign w_sb_last = r_sb_pipe[MEM_LAT-1];

  generate
    if (PIX_W >= 4) begin : g_map_wide
      logic w_pix_unused;
      assign w_pix_unused = ^frame_pixel;
      assign w_pix4       = frame_pixel[PIX_W-1 -: 4];
    end else begin : g_map_narrow
      for (genvar gb = 0; gb < 4; gb++) begin : g_rep
        assign w_pix4[3-gb] = frame_pixel[PIX_W-1-(gb % PIX_W)];
      end
    end
  endgenerate

  assign w_gray = w_sb_last[c_SB_TEST] ? w_sb_last[3:0] : w_pix4;

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb   <= 4'h0;
      r_de    <= 1'b0;
      r_hsync <= ~HSYNC_ACTIVE;
      r_vsync <= ~VSYNC_ACTIVE;
      r_fs    <= 1'b0;
    end else begin
      r_rgb   <= w_sb_last[c_SB_DE] ? w_gray : 4'h0;
      r_de    <= w_sb_last[c_SB_DE];
      r_hsync <= w_sb_last[c_SB_HS];
      r_vsync <= w_sb_last[c_SB_VS];
      r_fs    <= w_sb_last[c_SB_FS];
    end
  end

  assign frame_addr  = r_frame_addr;
  assign vga_red     = r_rgb;
  assign vga_green   = r_rgb;
  assign vga_blue    = r_rgb;
  assign vga_hsync   = r_hsync;
  assign vga_vsync   = r_vsync;
  assign de          = r_de;
  assign frame_start = r_fs;

endmodule
`default_nettype wire

// File: tb/tb_vga_scaled_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vga_scaled_reader                                                     |
// | Scoreboard bench: reduced 128x48 timing, modes 0/1/2/3, async reset.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_vga_scaled_reader;

  localparam int H_REZ   = 128;
  localparam int H_FP    = 4;
  localparam int H_SYNC  = 8;
  localparam int H_BP    = 4;
  localparam int V_REZ   = 48;
  localparam int V_FP    = 2;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 2;
  localparam int H_TOTAL = H_REZ + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_REZ + V_FP + V_SYNC + V_BP;
  localparam int PIX_W   = 4;
  localparam int ADDR_W  = 13;
  localparam int MEM_LAT = 2;

  logic              clk25 = 1'b0;
  logic              rst_n = 1'b0;
  logic [1:0]        mode  = 2'd0;
  logic [ADDR_W-1:0] frame_addr;
  logic [PIX_W-1:0]  frame_pixel = '0;
  logic [3:0]        vga_red, vga_green, vga_blue;
  logic              vga_hsync, vga_vsync, de, frame_start;

  always #5 clk25 = ~clk25;

  vga_scaled_reader #(
    .H_REZ(H_REZ), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_REZ(V_REZ), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HSYNC_ACTIVE(1'b0), .VSYNC_ACTIVE(1'b0),
    .PIX_W(PIX_W), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)
  ) dut (
    .clk25(clk25), .rst_n(rst_n), .mode(mode),
    .frame_addr(frame_addr), .frame_pixel(frame_pixel),
    .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .de(de), .frame_start(frame_start)
  );

  // RAM model: frame_pixel is captured by the DUT MEM_LAT cycles after the
  // address is launched, i.e. one register stage here for MEM_LAT = 2.
  function automatic logic [3:0] ram_fn(input logic [ADDR_W-1:0] a);
    return a[3:0] ^ a[7:4] ^ a[11:8];
  endfunction

  always @(posedge clk25) frame_pixel <= ram_fn(frame_addr);

  typedef struct { int due; int md; int h; int v; logic [ADDR_W-1:0] addr; } arec_t;
  typedef struct { int due; int md; int h; int v; logic [15:0] outv; } orec_t;
  typedef struct { int md; int h; int v; int val; } dvec_t;

  arec_t aq[$];
  orec_t oq[$];
  arec_t a_rec;
  orec_t o_rec;

  // Hand-computed addresses for the 128-wide source at each scale
  localparam int N_DA = 8;
  dvec_t da_tab [N_DA] = '{
    '{0,   5,  0,    5}, '{0,   0,  1,  128}, '{0, 127, 47, 6143},
    '{1,   3,  3,   65}, '{1, 127,  1,   63}, '{1, 127, 47, 1535},
    '{2,   0,  4,   32}, '{2, 127, 47,  383}
  };
  // Hand-computed test-pattern gray levels
  localparam int N_DR = 5;
  dvec_t dr_tab [N_DR] = '{
    '{3, 64, 0, 1}, '{3, 64, 32, 14}, '{3, 0, 31, 0}, '{3, 0, 32, 15}, '{3, 127, 33, 14}
  };

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic mon_en   = 1'b0;

  int k, m_h, m_v, m_mq, fnum;

  always @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Monitor: pops expected records as the DUT presents each output cycle
  always @(negedge clk25) begin
    if (mon_en && rst_n) begin
      if (aq.size() > 0 && aq[0].due == cyc) begin
        a_rec = aq.pop_front();
        checks++;
        if (frame_addr !== a_rec.addr) begin
          failures++;
          $display("FAIL addr md=%0d h=%0d v=%0d: got %0d required %0d",
                   a_rec.md, a_rec.h, a_rec.v, frame_addr, a_rec.addr);
        end
        for (int i = 0; i < N_DA; i++) begin
          if (da_tab[i].md == a_rec.md && da_tab[i].h == a_rec.h && da_tab[i].v == a_rec.v) begin
            checks++;
            if (frame_addr !== ADDR_W'(da_tab[i].val)) begin
              failures++;
              $display("FAIL dir_addr[%0d]: got %0d required %0d", i, frame_addr, da_tab[i].val);
            end
          end
        end
      end
      if (oq.size() > 0 && oq[0].due == cyc) begin
        o_rec = oq.pop_front();
        checks++;
        if ({de, vga_hsync, vga_vsync, frame_start, vga_red, vga_green, vga_blue} !== o_rec.outv) begin
          failures++;
          $display("FAIL video md=%0d h=%0d v=%0d: got {de,hs,vs,fs,rgb}=%h required %h",
                   o_rec.md, o_rec.h, o_rec.v,
                   {de, vga_hsync, vga_vsync, frame_start, vga_red, vga_green, vga_blue}, o_rec.outv);
        end
        for (int i = 0; i < N_DR; i++) begin
          if (dr_tab[i].md == o_rec.md && dr_tab[i].h == o_rec.h && dr_tab[i].v == o_rec.v) begin
            checks++;
            if ({vga_red, vga_green, vga_blue} !== {3{4'(dr_tab[i].val)}}) begin
              failures++;
              $display("FAIL dir_rgb[%0d]: got %h required %h", i,
                       {vga_red, vga_green, vga_blue}, {3{4'(dr_tab[i].val)}});
            end
          end
        end
      end else if (de === 1'b1) begin
        checks++;
        failures++;
        $display("FAIL unexpected_de cyc=%0d: got de=1 required no output", cyc);
      end
    end
  end

  task automatic check_reset(input string name);
    checks++;
    if (frame_addr !== '0 || de !== 1'b0 || vga_hsync !== 1'b1 || vga_vsync !== 1'b1 ||
        frame_start !== 1'b0 || {vga_red, vga_green, vga_blue} !== 12'h000) begin
      failures++;
      $display("FAIL %s: got addr=%0d de=%b hs=%b vs=%b fs=%b rgb=%h required addr=0 de=0 hs=1 vs=1 fs=0 rgb=000",
               name, frame_addr, de, vga_hsync, vga_vsync, frame_start, {vga_red, vga_green, vga_blue});
    end
  endtask

  // Reference model for the counters state of the current cycle
  task automatic push_model();
    logic       act, hs, vs, fs;
    int         s, addr;
    logic [3:0] rgb;
    arec_t      ar;
    orec_t      orr;
    if (m_h == 0 && m_v == 0) begin
      m_mq = int'(mode);
      fnum++;
    end
    act  = (m_h < H_REZ) && (m_v < V_REZ);
    s    = (m_mq == 3) ? 0 : m_mq;
    addr = (act && m_mq != 3) ? (m_v >> s) * (H_REZ >> s) + (m_h >> s) : 0;
    if (!act)           rgb = 4'h0;
    else if (m_mq == 3) rgb = 4'((m_h >> 6) & 15) ^ ((((m_v >> 5) & 1) != 0) ? 4'hF : 4'h0);
    else                rgb = ram_fn(ADDR_W'(addr));
    hs = (m_h >= H_REZ + H_FP && m_h < H_REZ + H_FP + H_SYNC) ? 1'b0 : 1'b1;
    vs = (m_v >= V_REZ + V_FP && m_v < V_REZ + V_FP + V_SYNC) ? 1'b0 : 1'b1;
    fs = (m_h == 0 && m_v == 0);
    ar.due = k + 1; ar.md = m_mq; ar.h = m_h; ar.v = m_v; ar.addr = ADDR_W'(addr);
    aq.push_back(ar);
    orr.due = k + MEM_LAT + 1; orr.md = m_mq; orr.h = m_h; orr.v = m_v;
    orr.outv = {act, hs, vs, fs, rgb, rgb, rgb};
    oq.push_back(orr);
  endtask

  task automatic advance();
    m_h++;
    if (m_h == H_TOTAL) begin
      m_h = 0;
      m_v++;
      if (m_v == V_TOTAL) m_v = 0;
    end
  endtask

  // Frame plan: 0 -> 1 -> 0 (switch to 2 mid-frame) -> 2 -> 3 -> 3
  task automatic schedule();
    if (m_h == 5 && m_v == 0) begin
      case (fnum)
        0: mode = 2'd1;
        1: mode = 2'd0;
        3: mode = 2'd3;
        default: ;
      endcase
    end
    if (m_h == 5 && m_v == 10 && fnum == 2) mode = 2'd2;
  endtask

  initial begin
    rst_n = 1'b0;
    mode  = 2'd0;
    repeat (3) @(negedge clk25);
    check_reset("reset_hold_a");
    repeat (2) @(negedge clk25);
    check_reset("reset_hold_b");
    k    = 0;
    m_h  = 0;
    m_v  = 0;
    m_mq = 0;
    fnum = -1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    push_model();
    repeat (5 * H_TOTAL * V_TOTAL + H_TOTAL + 70) begin
      @(negedge clk25);
      k++;
      advance();
      schedule();
      push_model();
    end
    // Mid-line, mid-cycle reset while the test pattern is on screen
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_reset("async_reset_mid_line");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its end, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
